// File: rtl/led_bank_arbiter_if.sv
// LED bank arbiter pin bundle: raw buttons in, LED bank and status out.
interface led_bank_arbiter_if;
   logic       button_0;
   logic       button_1;
   logic [2:0] led;
   logic [1:0] grant;
   logic [1:0] pending;
   logic       busy;

   // Board/driver side: owns the raw buttons, observes the bank.
   modport master (output button_0, button_1, input led, grant, pending, busy);
   // Arbiter side.
   modport slave (input button_0, button_1, output led, grant, pending, busy);
endinterface

// File: rtl/led_bank_arbiter.sv
// LED bank arbiter: two debounced active-low requesters share a 3-bit LED
// bank; round-robin grant, each owner plays a chase pattern for a fixed
// session before the bank is handed on.
module led_bank_arbiter #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int STEP_CYCLES     = 6000000,
   parameter int HOLD_STEPS      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   led_bank_arbiter_if.slave bus
);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   logic [1:0]    btn_raw;
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    deb_q, deb_d;
   logic [DW-1:0] dcnt_q [2];
   logic [DW-1:0] dcnt_d [2];
   logic [1:0]    press;

   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic [2:0]    led_q, led_d;
   logic [SW-1:0] step_q, step_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0]    pend_q, pend_d;
   logic [1:0]    clr;
   logic          win, step_end, sess_end;

   assign btn_raw = {bus.button_1, bus.button_0};

   // Two-flop synchroniser; idles at released (high) so reset never fakes a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: level flips after DEBOUNCE_CYCLES consecutive mismatching cycles.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i]  = deb_q[i];
         dcnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync2_q[i];
            else dcnt_d[i] = dcnt_q[i] + 1'b1;
         end
      end
   end

   // A press is the debounced 1->0 edge, seen on the same clock as the flip.
   assign press = deb_q & ~deb_d;

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q     <= 2'b11;
         dcnt_q[0] <= '0;
         dcnt_q[1] <= '0;
      end else begin
         deb_q     <= deb_d;
         dcnt_q[0] <= dcnt_d[0];
         dcnt_q[1] <= dcnt_d[1];
      end
   end

   // Arbiter FSM next-state, pattern/timers, request queue and outputs.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      led_d       = led_q;
      step_d      = step_q;
      hold_d      = hold_q;
      clr         = 2'b00;
      bus.led     = 3'b000;
      bus.grant   = 2'b00;
      bus.busy    = 1'b0;
      // Sole pending bit wins; on a tie, the requester not served last wins.
      win         = (pend_q == 2'b11) ? ~last_q : pend_q[1];
      step_end    = (step_q == SW'(STEP_CYCLES - 1));
      sess_end    = step_end && (hold_q == HW'(HOLD_STEPS - 1));
      case (state_q)
         IDLE: begin
            if (pend_q != 2'b00) begin
               state_d  = RUN;
               owner_d  = win;
               clr[win] = 1'b1;
               led_d    = win ? 3'b100 : 3'b001;
               step_d   = '0;
               hold_d   = '0;
            end
         end
         RUN: begin
            bus.led   = led_q;
            bus.grant = owner_q ? 2'b10 : 2'b01;
            bus.busy  = 1'b1;
            if (step_end) begin
               step_d = '0;
               hold_d = hold_q + 1'b1;
               led_d  = owner_q ? {led_q[0], led_q[2:1]} : {led_q[1:0], led_q[2]};
               if (sess_end) begin
                  state_d = IDLE;
                  last_d  = owner_q;
                  hold_d  = '0;
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // New presses are OR'd after the grant clear so a same-edge press re-queues.
      pend_d      = (pend_q & ~clr) | press;
      bus.pending = pend_q;
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         led_q   <= 3'b000;
         step_q  <= '0;
         hold_q  <= '0;
         pend_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         led_q   <= led_d;
         step_q  <= step_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
      end
   end
endmodule
